// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, redirect flushes, data-memory freeze, sticky halt.
// Outputs are combinational from state and inputs; stall/mem_stall hold upstream stages, flush_* squash them.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        dec_valid,
    input  logic [4:0]  dec_s_1,
    input  logic [4:0]  dec_s_2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_tgt_1,
    input  logic [4:0]  ex_tgt_2,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        br_taken,
    input  logic        wb_redirect,
    input  logic        wb_halt,
    output logic        stall,
    output logic        ex_bubble,
    output logic        flush_front,
    output logic        flush_back,
    output logic        mem_stall,
    output logic        halt,
    output logic [1:0]  state_out,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT   = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] CNT_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    // A single-cycle flush is fully covered by the redirect cycle itself.
    localparam state_t     REDIR_ST   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q;

    logic hit_1, hit_2, lu, mem_wait;
    logic stall_c, bubble_c, ff_c, fb_c, ms_c, halt_c;

    assign hit_1    = (ex_tgt_1 != 5'd0) && ((ex_tgt_1 == dec_s_1) || (ex_tgt_1 == dec_s_2));
    assign hit_2    = (ex_tgt_2 != 5'd0) && ((ex_tgt_2 == dec_s_1) || (ex_tgt_2 == dec_s_2));
    assign lu       = dec_valid && ex_valid && ex_is_load && (hit_1 || hit_2);
    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        ff_c     = 1'b0;
        fb_c     = 1'b0;
        ms_c     = 1'b0;
        halt_c   = 1'b0;
        case (state_q)
            RUN: begin
                if (wb_halt) begin
                    ff_c    = 1'b1;
                    fb_c    = 1'b1;
                    state_d = HALTED;
                end else if (wb_redirect) begin
                    ff_c    = 1'b1;
                    fb_c    = 1'b1;
                    state_d = REDIR_ST;
                    cnt_d   = CNT_RELOAD;
                end else if (mem_wait) begin
                    stall_c = 1'b1;
                    ms_c    = 1'b1;
                    state_d = MEM_WAIT;
                end else if (br_taken) begin
                    ff_c    = 1'b1;
                    state_d = REDIR_ST;
                    cnt_d   = CNT_RELOAD;
                end else if (lu) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Back end is frozen, so redirects and hazards wait for the access to finish.
                stall_c = !mem_ready;
                ms_c    = !mem_ready;
                if (mem_ready) state_d = RUN;
            end
            FLUSH: begin
                ff_c = 1'b1;
                if (wb_halt) begin
                    state_d = HALTED;
                end else if (wb_redirect) begin
                    fb_c    = 1'b1;
                    state_d = REDIR_ST;
                    cnt_d   = CNT_RELOAD;
                end else if (mem_wait) begin
                    stall_c = 1'b1;
                    ms_c    = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                halt_c  = 1'b1;
                stall_c = 1'b1;
                ms_c    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FLUSH;
            cnt_q       <= CNT_INIT;
            stall_cnt_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_c && (state_q != HALTED) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Held in reset the block presents a pure front-end flush regardless of inputs.
    assign stall       = rst_n && stall_c;
    assign ex_bubble   = rst_n && bubble_c;
    assign flush_front = !rst_n || ff_c;
    assign flush_back  = rst_n && fb_c;
    assign mem_stall   = rst_n && ms_c;
    assign halt        = rst_n && halt_c;
    assign state_out   = state_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipe_hazard_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        dec_valid = 1'b0;
    logic [4:0]  dec_s_1 = 5'd0;
    logic [4:0]  dec_s_2 = 5'd0;
    logic        ex_valid = 1'b0;
    logic        ex_is_load = 1'b0;
    logic [4:0]  ex_tgt_1 = 5'd0;
    logic [4:0]  ex_tgt_2 = 5'd0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        wb_redirect = 1'b0;
    logic        wb_halt = 1'b0;
    logic        stall, ex_bubble, flush_front, flush_back, mem_stall, halt;
    logic [1:0]  state_out;
    logic [31:0] stall_count;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .dec_valid(dec_valid), .dec_s_1(dec_s_1), .dec_s_2(dec_s_2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_tgt_1(ex_tgt_1), .ex_tgt_2(ex_tgt_2),
        .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
        .wb_redirect(wb_redirect), .wb_halt(wb_halt),
        .stall(stall), .ex_bubble(ex_bubble), .flush_front(flush_front), .flush_back(flush_back),
        .mem_stall(mem_stall), .halt(halt), .state_out(state_out), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: halted / waiting-on-memory flags plus number of flush cycles still owed.
    logic        m_halted = 1'b0;
    logic        m_waiting = 1'b0;
    int          m_left = FC;
    logic [31:0] m_cnt = 32'd0;
    int          preset_seq = 0;
    int          last_seq = 0;
    logic [31:0] preset_val = 32'd0;

    function automatic logic [5:0] exp_out();
        logic s = 1'b0, b = 1'b0, f = 1'b0, k = 1'b0, m = 1'b0, h = 1'b0;
        logic lu, mw;
        lu = dec_valid && ex_valid && ex_is_load &&
             ((ex_tgt_1 != 0 && (ex_tgt_1 == dec_s_1 || ex_tgt_1 == dec_s_2)) ||
              (ex_tgt_2 != 0 && (ex_tgt_2 == dec_s_1 || ex_tgt_2 == dec_s_2)));
        mw = mem_req && !mem_ready;
        if (!rst_n) f = 1'b1;
        else if (m_halted) begin h = 1'b1; s = 1'b1; m = 1'b1; end
        else if (m_waiting) begin s = !mem_ready; m = !mem_ready; end
        else if (m_left > 0) begin
            f = 1'b1;
            if (wb_halt) f = 1'b1;
            else if (wb_redirect) k = 1'b1;
            else if (mw) begin s = 1'b1; m = 1'b1; end
        end
        else if (wb_halt || wb_redirect) begin f = 1'b1; k = 1'b1; end
        else if (mw) begin s = 1'b1; m = 1'b1; end
        else if (br_taken) f = 1'b1;
        else if (lu) begin s = 1'b1; b = 1'b1; end
        return {s, b, f, k, m, h};
    endfunction

    function automatic logic [1:0] exp_state();
        if (!rst_n) return 2'd2;
        if (m_halted) return 2'd3;
        if (m_waiting) return 2'd1;
        if (m_left > 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] cur_cnt();
        return (preset_seq != last_seq) ? preset_val : m_cnt;
    endfunction

    function automatic logic [31:0] next_cnt();
        logic [5:0]  o = exp_out();
        logic [31:0] c = cur_cnt();
        if (clk_en && o[5] && !m_halted && c != 32'hFFFF_FFFF) return c + 32'd1;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halted  <= 1'b0;
            m_waiting <= 1'b0;
            m_left    <= FC;
            m_cnt     <= 32'd0;
            last_seq  <= preset_seq;
        end else begin
            m_cnt    <= next_cnt();
            last_seq <= preset_seq;
            if (clk_en && !m_halted) begin
                if (m_waiting) begin
                    if (mem_ready) m_waiting <= 1'b0;
                end else if (m_left > 0) begin
                    if (wb_halt) m_halted <= 1'b1;
                    else if (wb_redirect) m_left <= FC - 1;
                    else if (!(mem_req && !mem_ready)) m_left <= m_left - 1;
                end else if (wb_halt) m_halted <= 1'b1;
                else if (wb_redirect) m_left <= FC - 1;
                else if (mem_req && !mem_ready) m_waiting <= 1'b1;
                else if (br_taken) m_left <= FC - 1;
            end
        end
    end

    task automatic check_all();
        logic [5:0] o = exp_out();
        check("stall", 32'(stall), 32'(o[5]));
        check("ex_bubble", 32'(ex_bubble), 32'(o[4]));
        check("flush_front", 32'(flush_front), 32'(o[3]));
        check("flush_back", 32'(flush_back), 32'(o[2]));
        check("mem_stall", 32'(mem_stall), 32'(o[1]));
        check("halt", 32'(halt), 32'(o[0]));
        check("state", 32'(state_out), 32'(exp_state()));
        check("stall_count", stall_count, cur_cnt());
    endtask

    always @(negedge clk) check_all();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        dec_valid = 0; dec_s_1 = 0; dec_s_2 = 0; ex_valid = 0; ex_is_load = 0;
        ex_tgt_1 = 0; ex_tgt_2 = 0; mem_req = 0; mem_ready = 0;
        br_taken = 0; wb_redirect = 0; wb_halt = 0;
    endtask

    task automatic set_lu();
        dec_valid = 1; dec_s_1 = 5'd3; dec_s_2 = 5'd5;
        ex_valid = 1; ex_is_load = 1; ex_tgt_1 = 5'd5; ex_tgt_2 = 5'd0;
    endtask

    initial begin
        int c;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ff", 32'(flush_front), 1);
        check("rst_state", 32'(state_out), 2);
        check("rst_cnt", stall_count, 0);

        // Reset release: flush for FC cycles, then RUN.
        tick(); rst_n = 1;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c += int'(flush_front);
        end
        check("rst_flush_len", c, 2);
        check("run_state", 32'(state_out), 0);

        // Load-use hazard and its non-hazard variants.
        tick(); set_lu();
        @(negedge clk); check("lu_stall", 32'(stall), 1); check("lu_bubble", 32'(ex_bubble), 1);
        tick(); ex_valid = 0;
        @(negedge clk); check("lu_clear", 32'(stall), 0);
        tick(); ex_valid = 1; ex_tgt_1 = 5'd0;
        @(negedge clk); check("lu_r0", 32'(stall), 0);
        tick(); ex_tgt_1 = 5'd5; dec_valid = 0;
        @(negedge clk); check("lu_nodec", 32'(stall), 0);
        tick(); dec_valid = 1; ex_tgt_1 = 5'd9; ex_tgt_2 = 5'd3;
        @(negedge clk); check("lu_tgt2", 32'(stall), 1);
        tick(); clear_in();
        @(negedge clk); check("sc_after_lu", stall_count, 2);

        // Memory wait for 3 cycles, branch arriving mid-wait.
        tick(); mem_req = 1; mem_ready = 0;
        @(negedge clk); check("mw1_stall", 32'(mem_stall), 1); check("mw1_state", 32'(state_out), 0);
        tick();
        @(negedge clk); check("mw2_state", 32'(state_out), 1);
        tick(); br_taken = 1;
        @(negedge clk); check("mw3_stall", 32'(stall), 1); check("mw3_ff", 32'(flush_front), 0);
        tick(); mem_ready = 1;
        @(negedge clk); check("mw_rdy_stall", 32'(stall), 0); check("mw_rdy_ff", 32'(flush_front), 0);
        tick(); mem_req = 0; mem_ready = 0;
        @(negedge clk); check("mw_br_ff", 32'(flush_front), 1); check("mw_sc", stall_count, 5);
        tick(); br_taken = 0;
        tick();

        // Taken branch, WB redirect, and both together.
        tick(); br_taken = 1;
        @(negedge clk); check("br_fb", 32'(flush_back), 0); check("br_ff", 32'(flush_front), 1);
        tick(); br_taken = 0;
        @(negedge clk); check("br_ff2", 32'(flush_front), 1);
        tick();
        @(negedge clk); check("br_done", 32'(flush_front), 0);
        tick(); wb_redirect = 1;
        @(negedge clk); check("rd_fb", 32'(flush_back), 1);
        tick(); wb_redirect = 0;
        @(negedge clk); check("rd_fb2", 32'(flush_back), 0); check("rd_ff2", 32'(flush_front), 1);
        tick(); wb_redirect = 1; br_taken = 1;
        @(negedge clk); check("both_fb", 32'(flush_back), 1);
        tick(); clear_in();
        tick();

        // Memory wait during a flush: stall and flush together, counter held.
        tick(); br_taken = 1;
        tick(); br_taken = 0; mem_req = 1;
        @(negedge clk); check("fm_stall", 32'(stall), 1); check("fm_ff", 32'(flush_front), 1);
        tick(); mem_ready = 1;
        @(negedge clk); check("fm_state", 32'(state_out), 2);
        tick(); mem_req = 0; mem_ready = 0;
        @(negedge clk); check("fm_run", 32'(state_out), 0);

        // Clock enable low freezes state and counter.
        tick(); clk_en = 0; set_lu();
        @(negedge clk); check("ce_stall", 32'(stall), 1);
        tick();
        @(negedge clk); check("ce_sc", stall_count, 6);
        tick(); clear_in(); clk_en = 1;

        // Halt, then asynchronous reset out of HALTED.
        tick(); wb_halt = 1;
        tick(); wb_halt = 0;
        @(negedge clk); check("h_halt", 32'(halt), 1); check("h_state", 32'(state_out), 3);
        repeat (3) tick();
        @(negedge clk); check("h_sc", stall_count, 6);
        tick(); #3 rst_n = 0; #1;
        check("ar_halt", 32'(halt), 0); check("ar_ff", 32'(flush_front), 1);
        check("ar_sc", stall_count, 0);
        tick(); tick(); rst_n = 1;
        repeat (3) tick();

        // Saturation from a preset near the top.
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        preset_val = 32'hFFFF_FFFE;
        preset_seq++;
        #1 release dut.stall_cnt_q;
        mem_req = 1; mem_ready = 0;
        repeat (3) tick();
        mem_ready = 1;
        @(negedge clk); check("sat_max", stall_count, 32'hFFFF_FFFF);
        tick(); mem_req = 0; mem_ready = 0;
        tick();
        @(negedge clk); check("sat_hold", stall_count, 32'hFFFF_FFFF);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
